// File: rtl/conv_event_arbiter.sv
// conv_event_arbiter: round-robin sharing of one convolution core between
// N_REQ event-capture channels, with a timestep-marker barrier.
// Optional build macro ARB_ACK_TIMEOUT_EN adds a conv_ack watchdog in GRANT
// and the timeout_err output; without it GRANT waits indefinitely.
module conv_event_arbiter #(
  parameter int N_REQ       = 4,
  parameter int EVENT_WIDTH = 24,
  parameter int SRC_WIDTH   = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [N_REQ-1:0]             req_mask,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ-1:0]             req_is_ts,
  input  logic [N_REQ*EVENT_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]             req_ack,
  input  logic                         conv_ready,
  output logic                         event_valid,
  output logic [EVENT_WIDTH-1:0]       event_data,
  output logic [SRC_WIDTH-1:0]         event_src,
  input  logic                         conv_ack,
  output logic                         ts_start,
  input  logic                         ts_done,
  output logic                         busy
`ifdef ARB_ACK_TIMEOUT_EN
  ,
  output logic                         timeout_err
`endif
);

  typedef enum logic [2:0] {
    ST_ARB      = 3'd0,
    ST_GRANT    = 3'd1,
    ST_TS_ACK   = 3'd2,
    ST_TS_START = 3'd3,
    ST_TS_WAIT  = 3'd4
  } state_t;

  // Unsupported parameter combinations show up as this named block in the
  // elaborated hierarchy.
  if (N_REQ < 2 || N_REQ > 16 || ACK_TIMEOUT < 1) begin : g_unsupported_config
  end

  state_t                   state_q, state_d;
  logic [N_REQ-1:0]         ts_seen_q, ts_seen_d;
  logic [SRC_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]         req_ack_q, req_ack_d;
  logic                     event_valid_q, event_valid_d;
  logic [EVENT_WIDTH-1:0]   event_data_q, event_data_d;
  logic [SRC_WIDTH-1:0]     event_src_q, event_src_d;
  logic                     ts_start_q, ts_start_d;
  logic                     busy_q, busy_d;

`ifdef ARB_ACK_TIMEOUT_EN
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  logic [CNT_W-1:0]         ack_cnt_q, ack_cnt_d;
  logic                     timeout_err_q, timeout_err_d;
`endif

  logic [EVENT_WIDTH-1:0]   req_word [N_REQ];
  logic [N_REQ-1:0]         eligible;
  logic                     barrier_hit;
  logic                     win_found;
  logic [SRC_WIDTH-1:0]     win_idx;

  // Split the flat head-word bus and form per-channel eligibility.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_chan
    assign req_word[gi] = req_data[gi*EVENT_WIDTH +: EVENT_WIDTH];
    assign eligible[gi] = req_valid[gi] & req_mask[gi] & ~ts_seen_q[gi];
  end

  // Every participating channel has delivered its marker; masked channels
  // count as done so they never hold the barrier up.
  assign barrier_hit = (req_mask != '0) && (&(ts_seen_q | ~req_mask));

  // Round-robin search: first eligible channel strictly after rr_ptr.
  always_comb begin
    logic [SRC_WIDTH-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = SRC_WIDTH'((int'(rr_ptr_q) + k) % N_REQ);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and next-output computation for the arbiter sequence.
  always_comb begin
    state_d       = state_q;
    ts_seen_d     = ts_seen_q;
    rr_ptr_d      = rr_ptr_q;
    req_ack_d     = '0;
    event_valid_d = event_valid_q;
    event_data_d  = event_data_q;
    event_src_d   = event_src_q;
    ts_start_d    = 1'b0;
`ifdef ARB_ACK_TIMEOUT_EN
    ack_cnt_d     = ack_cnt_q;
    timeout_err_d = 1'b0;
`endif

    case (state_q)
      ST_ARB: begin
        if (barrier_hit) begin
          // Barrier wins over grants and ignores enable.
          state_d    = ST_TS_START;
          ts_start_d = 1'b1;
        end else if (enable && win_found) begin
          if (req_is_ts[win_idx]) begin
            // Markers are consumed locally; the core never sees them.
            state_d            = ST_TS_ACK;
            ts_seen_d[win_idx] = 1'b1;
            req_ack_d[win_idx] = 1'b1;
            rr_ptr_d           = win_idx;
          end else if (conv_ready) begin
            state_d            = ST_GRANT;
            event_valid_d      = 1'b1;
            event_data_d       = req_word[win_idx];
            event_src_d        = win_idx;
            req_ack_d[win_idx] = 1'b1;
            rr_ptr_d           = win_idx;
`ifdef ARB_ACK_TIMEOUT_EN
            ack_cnt_d          = '0;
`endif
          end
        end
      end

      ST_GRANT: begin
        if (conv_ack) begin
          event_valid_d = 1'b0;
          state_d       = ST_ARB;
        end
`ifdef ARB_ACK_TIMEOUT_EN
        else if (ack_cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          // Core never answered: drop the event and report it.
          event_valid_d = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = ST_ARB;
        end else begin
          ack_cnt_d = ack_cnt_q + CNT_W'(1);
        end
`endif
      end

      ST_TS_ACK: begin
        state_d = ST_ARB;
      end

      ST_TS_START: begin
        state_d = ST_TS_WAIT;
      end

      ST_TS_WAIT: begin
        if (ts_done) begin
          ts_seen_d = '0;
          state_d   = ST_ARB;
        end
      end

      default: begin
        state_d = ST_ARB;
      end
    endcase

    busy_d = (state_d != ST_ARB);
  end

  // All state and outputs are registered; reset is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_ARB;
      ts_seen_q     <= '0;
      rr_ptr_q      <= SRC_WIDTH'(N_REQ - 1);
      req_ack_q     <= '0;
      event_valid_q <= 1'b0;
      event_data_q  <= '0;
      event_src_q   <= '0;
      ts_start_q    <= 1'b0;
      busy_q        <= 1'b0;
`ifdef ARB_ACK_TIMEOUT_EN
      ack_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      ts_seen_q     <= ts_seen_d;
      rr_ptr_q      <= rr_ptr_d;
      req_ack_q     <= req_ack_d;
      event_valid_q <= event_valid_d;
      event_data_q  <= event_data_d;
      event_src_q   <= event_src_d;
      ts_start_q    <= ts_start_d;
      busy_q        <= busy_d;
`ifdef ARB_ACK_TIMEOUT_EN
      ack_cnt_q     <= ack_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign req_ack     = req_ack_q;
  assign event_valid = event_valid_q;
  assign event_data  = event_data_q;
  assign event_src   = event_src_q;
  assign ts_start    = ts_start_q;
  assign busy        = busy_q;
`ifdef ARB_ACK_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`endif

endmodule

// File: tb/tb_conv_event_arbiter.sv
// Self-checking bench for conv_event_arbiter: per-channel FIFOs feed the DUT,
// a behavioural model predicts every output each cycle, and a few directed
// scenarios pin literal expectations.
module tb_conv_event_arbiter;
  localparam int NR = 4;
  localparam int EW = 24;
  localparam int SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, enable, conv_ready, conv_ack, ts_done;
  logic [NR-1:0]     req_mask, req_valid, req_is_ts, req_ack;
  logic [NR*EW-1:0]  req_data;
  logic              event_valid, ts_start, busy;
  logic [EW-1:0]     event_data;
  logic [SW-1:0]     event_src;

  conv_event_arbiter #(.N_REQ(NR), .EVENT_WIDTH(EW), .SRC_WIDTH(SW), .ACK_TIMEOUT(1024)) dut (
    .clk(clk), .rst(rst), .enable(enable), .req_mask(req_mask),
    .req_valid(req_valid), .req_is_ts(req_is_ts), .req_data(req_data),
    .req_ack(req_ack), .conv_ready(conv_ready), .event_valid(event_valid),
    .event_data(event_data), .event_src(event_src), .conv_ack(conv_ack),
    .ts_start(ts_start), .ts_done(ts_done), .busy(busy)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Channel FIFOs as ring buffers of {is_ts, data}.
  logic [EW:0] fmem [NR][64];
  int f_rd [NR];
  int f_wr [NR];

  function automatic void push(input int ch, input logic ts, input logic [EW-1:0] d);
    fmem[ch][f_wr[ch] % 64] = {ts, d};
    f_wr[ch]++;
  endfunction

  // Stimulus knobs.
  logic          k_rst, k_en;
  logic [NR-1:0] k_mask;
  int            k_ready;      // 0/1 fixed, 2 random
  int            k_ack_delay;  // -1 random, else ack once valid held > delay cycles
  int            k_tsdone;     // 0 never, 1 random

  // Observations.
  int   cyc = 0;
  int   ev_cnt = 0;
  int   last_hold = 0;
  logic hold_ok = 1'b0;
  logic [EW-1:0] hold_data = '0;
  int   src_log [$];
  int   ts_start_cnt = 0;
  int   last_ts_cyc = 0;
  int   ack_pulse_cnt = 0;
  int   ch2_grant_cyc = -1;

  // Behavioural model: phase 0 idle/arbitrating, 1 event held at core,
  // 2 marker pop, 3 timestep pulse, 4 waiting for core.
  int            m_ph;
  logic [NR-1:0] m_seen;
  int            m_ptr;
  logic [NR-1:0] m_ack;
  logic          m_ev;
  logic [EW-1:0] m_data;
  int            m_src;
  logic          m_ts;

  task automatic model_step();
    logic [NR-1:0] elig;
    int w;
    if (rst) begin
      m_ph = 0; m_seen = '0; m_ptr = NR - 1; m_ack = '0;
      m_ev = 1'b0; m_data = '0; m_src = 0; m_ts = 1'b0;
      return;
    end
    m_ack = '0;
    m_ts  = 1'b0;
    case (m_ph)
      0: begin
        elig = req_valid & req_mask & ~m_seen;
        if (req_mask != 0 && (m_seen | ~req_mask) == {NR{1'b1}}) begin
          m_ph = 3; m_ts = 1'b1;
        end else if (enable && elig != 0) begin
          w = -1;
          for (int d = 1; d <= NR; d++)
            if (w < 0 && elig[(m_ptr + d) % NR]) w = (m_ptr + d) % NR;
          if (req_is_ts[w]) begin
            m_seen[w] = 1'b1; m_ack[w] = 1'b1; m_ptr = w; m_ph = 2;
          end else if (conv_ready) begin
            m_ack[w] = 1'b1; m_ptr = w; m_ph = 1;
            m_ev = 1'b1; m_data = req_data[w*EW +: EW]; m_src = w;
          end
        end
      end
      1: if (conv_ack) begin m_ev = 1'b0; m_ph = 0; end
      2: m_ph = 0;
      3: m_ph = 4;
      default: if (ts_done) begin m_seen = '0; m_ph = 0; end
    endcase
  endtask

  // One clock: drive inputs mid-cycle, step the model, check after the edge.
  task automatic cycle();
    @(negedge clk);
    rst = k_rst; enable = k_en; req_mask = k_mask;
    for (int i = 0; i < NR; i++) begin
      if (f_wr[i] > f_rd[i]) begin
        req_valid[i] = 1'b1;
        {req_is_ts[i], req_data[i*EW +: EW]} = fmem[i][f_rd[i] % 64];
      end else begin
        req_valid[i] = 1'b0;
        req_is_ts[i] = 1'($urandom);
        req_data[i*EW +: EW] = EW'($urandom);
      end
    end
    conv_ready = (k_ready == 2) ? ($urandom % 10 < 7) : k_ready[0];
    conv_ack   = (k_ack_delay < 0) ? ($urandom % 3 == 0) : (ev_cnt > k_ack_delay);
    ts_done    = (k_tsdone != 0) ? ($urandom % 4 == 0) : 1'b0;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    chk("req_ack", 64'(req_ack), 64'(m_ack));
    chk("event_valid", 64'(event_valid), 64'(m_ev));
    if (m_ev) begin
      chk("event_data", 64'(event_data), 64'(m_data));
      chk("event_src", 64'(event_src), 64'(m_src));
    end
    chk("ts_start", 64'(ts_start), 64'(m_ts));
    chk("busy", 64'(busy), 64'(m_ph != 0));
    chk("ack_onehot0", 64'($onehot0(req_ack)), 64'd1);
    chk("valid_ts_excl", 64'(event_valid & ts_start), 64'd0);
    if (event_valid) begin
      if (ev_cnt == 0) begin
        src_log.push_back(int'(event_src));
        hold_data = event_data;
        hold_ok = 1'b1;
        if (event_src == 2) ch2_grant_cyc = cyc;
      end else if (event_data !== hold_data) begin
        hold_ok = 1'b0;
      end
      ev_cnt++;
    end else begin
      if (ev_cnt > 0) last_hold = ev_cnt;
      ev_cnt = 0;
    end
    if (ts_start) begin ts_start_cnt++; last_ts_cyc = cyc; end
    if (req_ack != 0) ack_pulse_cnt++;
    for (int i = 0; i < NR; i++)
      if (req_ack[i] && f_wr[i] > f_rd[i]) f_rd[i]++;
  endtask

  function automatic logic fifos_empty();
    for (int i = 0; i < NR; i++) if (f_wr[i] > f_rd[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((!fifos_empty() || busy) && n < budget) begin
      cycle();
      n++;
    end
    chk(name, 64'(n < budget), 64'd1);
  endtask

  int exp_seq [5] = '{0, 1, 2, 3, 0};
  int base;
  logic got;

  initial begin
    for (int i = 0; i < NR; i++) begin f_rd[i] = 0; f_wr[i] = 0; end
    k_rst = 1'b1; k_en = 1'b1; k_mask = 4'hF;
    k_ready = 1; k_ack_delay = 1; k_tsdone = 1;
    repeat (2) cycle();
    chk("rst_event_valid", 64'(event_valid), 64'd0);
    chk("rst_req_ack", 64'(req_ack), 64'd0);
    chk("rst_ts_start", 64'(ts_start), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_event_data", 64'(event_data), 64'd0);
    chk("rst_event_src", 64'(event_src), 64'd0);
    k_rst = 1'b0;

    // conv_ready low holds everything back; then round-robin from channel 0.
    k_ready = 0;
    push(0, 1'b0, 24'h000A01); push(0, 1'b0, 24'h000A02);
    push(1, 1'b0, 24'h000B01); push(2, 1'b0, 24'h000C01); push(3, 1'b0, 24'h000D01);
    base = ack_pulse_cnt;
    repeat (8) cycle();
    chk("noready_no_ack", 64'(ack_pulse_cnt - base), 64'd0);
    chk("noready_no_valid", 64'(event_valid), 64'd0);
    k_ready = 1;
    cycle();
    chk("ready_grant_valid", 64'(event_valid), 64'd1);
    chk("ready_grant_src", 64'(event_src), 64'd0);
    chk("ready_grant_ack", 64'(req_ack), 64'b0001);
    chk("ready_grant_data", 64'(event_data), 64'h000A01);
    drain("drain_rr", 200);
    chk("rr_count", 64'(src_log.size()), 64'd5);
    for (int k = 0; k < 5; k++)
      if (k < src_log.size()) chk($sformatf("rr_src%0d", k), 64'(src_log[k]), 64'(exp_seq[k]));

    // Marker barrier with channel 2 reaching its marker first.
    k_ack_delay = -1; k_ready = 2; ch2_grant_cyc = -1; base = ts_start_cnt;
    push(0, 1'b0, 24'h100001); push(0, 1'b0, 24'h100002); push(0, 1'b1, 24'h1000FF);
    push(1, 1'b0, 24'h110001); push(1, 1'b1, 24'h1100FF);
    push(2, 1'b1, 24'h1200FF); push(2, 1'b0, 24'h120001);
    push(3, 1'b0, 24'h130001); push(3, 1'b0, 24'h130002); push(3, 1'b0, 24'h130003);
    push(3, 1'b1, 24'h1300FF);
    drain("drain_barrier", 600);
    chk("barrier_ts_count", 64'(ts_start_cnt - base), 64'd1);
    chk("ch2_after_barrier", 64'(ch2_grant_cyc > last_ts_cyc), 64'd1);

    // Long conv_ack stall: valid and data stay put for the whole hold.
    k_ready = 1; k_ack_delay = 50;
    push(1, 1'b0, 24'hABCDE1);
    drain("drain_hold", 200);
    chk("hold_len", 64'(last_hold), 64'd51);
    chk("hold_stable", 64'(hold_ok), 64'd1);
    chk("hold_data", 64'(hold_data), 64'hABCDE1);

    // Partial mask barrier, then reset while waiting for ts_done.
    k_ack_delay = -1; k_tsdone = 0; k_mask = 4'b0011; base = ts_start_cnt;
    push(0, 1'b1, 24'h2000FF); push(1, 1'b1, 24'h2100FF);
    repeat (12) cycle();
    chk("mask_barrier_ts", 64'(ts_start_cnt - base), 64'd1);
    chk("ts_wait_busy", 64'(busy), 64'd1);
    k_rst = 1'b1;
    cycle();
    k_rst = 1'b0;
    chk("wait_rst_valid", 64'(event_valid), 64'd0);
    chk("wait_rst_ts_start", 64'(ts_start), 64'd0);
    chk("wait_rst_busy", 64'(busy), 64'd0);
    chk("wait_rst_ack", 64'(req_ack), 64'd0);
    k_tsdone = 1;
    push(0, 1'b0, 24'h200001);
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      cycle();
      if (event_valid && event_src == 0) got = 1'b1;
    end
    chk("seen_cleared_grant", 64'(got), 64'd1);
    drain("drain_post_rst", 200);

    // Randomised traffic with mask changes, enable drops and resets.
    k_ready = 2; k_ack_delay = -1; k_tsdone = 1; k_mask = 4'hF;
    for (int n = 0; n < 3000; n++) begin
      k_rst = ($urandom % 300 == 0);
      k_en  = ($urandom % 10 != 0);
      if ($urandom % 100 == 0) k_mask = NR'($urandom);
      for (int i = 0; i < NR; i++)
        if (f_wr[i] - f_rd[i] < 4 && $urandom % 4 == 0)
          push(i, ($urandom % 5 == 0), EW'($urandom));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
